// File: rtl/timer_pkg.sv
// Constants shared between the 0.1 s timer and its consumers (state encoding, tick period).
package timer_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    localparam int unsigned TICK_CYCLES   = 12500000;
    localparam int          DEFAULT_WIDTH = 32;

endpackage

// File: rtl/elapsed_meter.sv
// Measures elapsed timer ticks and raw clock cycles between a start and a stop pulse,
// with optional tick-limit timeout and a sticky protocol-misuse flag.
module elapsed_meter
    import timer_pkg::*;
#(
    parameter int          WIDTH = DEFAULT_WIDTH,
    parameter int          CYC_W = 32,
    parameter int unsigned LIMIT = 0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] t,
    input  logic             start,
    input  logic             stop,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] elapsed_ticks,
    output logic [CYC_W-1:0] elapsed_cycles,
    output logic             timed_out,
    output logic             busy,
    output logic             err,
    input  logic             clr_err,
    output logic [1:0]       dbg_state
);

    // Result handshake: a result transfers on any rising edge where res_valid && res_ready.
    // Once res_valid rises, res_valid and all result fields hold until that transfer;
    // res_valid never depends combinationally on res_ready.

    logic [1:0]       state;
    logic [WIDTH-1:0] t_start;
    logic [WIDTH-1:0] diff;
    logic [CYC_W-1:0] cyc;
    logic [CYC_W-1:0] cyc_next;
    logic             limit_hit;
    logic             err_set;

    // Modular difference keeps the result correct across a rollover of t.
    assign diff      = t - t_start;
    assign cyc_next  = (&cyc) ? cyc : cyc + CYC_W'(1);
    assign limit_hit = (LIMIT != 0) && (diff >= WIDTH'(LIMIT));
    assign dbg_state = state;

    always_comb begin
        err_set = 1'b0;
        case (state)
            ST_RUN:  err_set = start;
            ST_HOLD: err_set = stop || (start && !res_ready);
            default: err_set = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= ST_IDLE;
            t_start        <= '0;
            cyc            <= '0;
            res_valid      <= 1'b0;
            elapsed_ticks  <= '0;
            elapsed_cycles <= '0;
            timed_out      <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        t_start <= t;
                        cyc     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // A stop in the same cycle as the limit is reported as a normal stop.
                    if (stop || limit_hit) begin
                        res_valid      <= 1'b1;
                        elapsed_ticks  <= diff;
                        elapsed_cycles <= cyc_next;
                        timed_out      <= !stop;
                        busy           <= 1'b0;
                        state          <= ST_HOLD;
                    end else begin
                        cyc <= cyc_next;
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (start) begin
                            t_start <= t;
                            cyc     <= '0;
                            busy    <= 1'b1;
                            state   <= ST_RUN;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Set events take priority over a same-cycle clear.
            if (err_set) begin
                err <= 1'b1;
            end else if (clr_err) begin
                err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_elapsed_meter.sv
// Directed bench for elapsed_meter: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares on every accepted result.
module tb_elapsed_meter;

    localparam int W  = 8;
    localparam int CW = 6;
    localparam int RW = W + CW + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [W-1:0]  t = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          res_ready = 1'b1;
    logic          clr_err = 1'b0;
    logic          res_valid;
    logic [W-1:0]  elapsed_ticks;
    logic [CW-1:0] elapsed_cycles;
    logic          timed_out;
    logic          busy;
    logic          err;
    logic [1:0]    dbg_state;

    logic [RW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_pass = 0;

    elapsed_meter #(.WIDTH(W), .CYC_W(CW), .LIMIT(5)) u_dut (
        .clk           (clk),
        .rstn          (rstn),
        .t             (t),
        .start         (start),
        .stop          (stop),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .elapsed_ticks (elapsed_ticks),
        .elapsed_cycles(elapsed_cycles),
        .timed_out     (timed_out),
        .busy          (busy),
        .err           (err),
        .clr_err       (clr_err),
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Driver tasks
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_result(input logic [W-1:0] tk, input logic [CW-1:0] cy, input logic to);
        exp_q.push_back({tk, cy, to});
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (rstn && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(res_valid), 32'(0));
            end else begin
                logic [RW-1:0] e;
                e = exp_q.pop_front();
                check("res_ticks", 32'(elapsed_ticks), 32'(e[RW-1 -: W]));
                check("res_cycles", 32'(elapsed_cycles), 32'(e[CW:1]));
                check("res_timed_out", 32'(timed_out), 32'(e[0]));
            end
        end
    end

    initial begin
        // Reset state
        step(3);
        rstn = 1'b1;
        check("rst_valid", 32'(res_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_state", 32'(dbg_state), 0);

        // Basic: 50 cycles, 3 ticks
        t = 8'd100; start = 1'b1; step(); start = 1'b0;
        check("basic_busy", 32'(busy), 1);
        check("basic_state_run", 32'(dbg_state), 1);
        step(49);
        t = 8'd103; stop = 1'b1;
        expect_result(8'd3, 6'd50, 1'b0);
        step(); stop = 1'b0;
        check("basic_valid", 32'(res_valid), 1);
        check("basic_busy_fall", 32'(busy), 0);
        step();
        check("basic_valid_1cyc", 32'(res_valid), 0);
        check("basic_state_idle", 32'(dbg_state), 0);
        check("basic_retain", 32'(elapsed_ticks), 3);

        // Stop alone in IDLE: ignored, no error
        stop = 1'b1; step(); stop = 1'b0;
        check("idle_stop_state", 32'(dbg_state), 0);
        check("idle_stop_err", 32'(err), 0);

        // Wrap: 250 -> 4 is 10 ticks; stop beats the limit in the same cycle
        t = 8'd250; start = 1'b1; step(); start = 1'b0;
        step(2);
        t = 8'd4; stop = 1'b1;
        expect_result(8'd10, 6'd3, 1'b0);
        step(); stop = 1'b0;
        check("wrap_valid", 32'(res_valid), 1);
        step();

        // Timeout at LIMIT=5
        t = 8'd0; start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            t = W'(k); step();
        end
        check("tmo_busy_before", 32'(busy), 1);
        t = 8'd5;
        expect_result(8'd5, 6'd5, 1'b1);
        step();
        check("tmo_valid", 32'(res_valid), 1);
        check("tmo_flag", 32'(timed_out), 1);
        step();

        // Stop on the timeout cycle wins
        t = 8'd0; start = 1'b1; step(); start = 1'b0;
        for (int k = 1; k < 5; k++) begin
            t = W'(k); step();
        end
        t = 8'd5; stop = 1'b1;
        expect_result(8'd5, 6'd5, 1'b0);
        step(); stop = 1'b0;
        check("tmo_stop_flag", 32'(timed_out), 0);
        step();

        // Misuse: second start in RUN flags error, keeps first t_start
        t = 8'd30; start = 1'b1; step();
        t = 8'd31; step(); start = 1'b0;
        check("misuse_err", 32'(err), 1);
        t = 8'd33; stop = 1'b1;
        expect_result(8'd3, 6'd2, 1'b0);
        step(); stop = 1'b0;
        step();
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("misuse_clr", 32'(err), 0);

        // Backpressure: hold result 20 cycles, pulses ignored but flagged
        res_ready = 1'b0;
        t = 8'd10; start = 1'b1; step(); start = 1'b0;
        step(3);
        t = 8'd12; stop = 1'b1;
        expect_result(8'd2, 6'd4, 1'b0);
        step(); stop = 1'b0;
        t = 8'd13;
        for (int i = 0; i < 20; i++) begin
            stop  = (i == 3);
            start = (i == 7);
            step();
            if (i == 0 || i == 5 || i == 10 || i == 19) begin
                check("bp_valid", 32'(res_valid), 1);
                check("bp_ticks", 32'(elapsed_ticks), 2);
                check("bp_cycles", 32'(elapsed_cycles), 4);
                check("bp_state", 32'(dbg_state), 2);
            end
        end
        stop = 1'b0; start = 1'b0;
        check("bp_err", 32'(err), 1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("bp_clr", 32'(err), 0);
        clr_err = 1'b1; stop = 1'b1; step(); clr_err = 1'b0; stop = 1'b0;
        check("bp_set_wins", 32'(err), 1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        check("bp_clr2", 32'(err), 0);
        t = 8'd20; res_ready = 1'b1; start = 1'b1; step(); start = 1'b0;
        check("bp_accept_valid", 32'(res_valid), 0);
        check("bp_accept_run", 32'(dbg_state), 1);
        check("bp_accept_busy", 32'(busy), 1);
        check("bp_accept_err", 32'(err), 0);
        step();
        t = 8'd21; stop = 1'b1;
        expect_result(8'd1, 6'd2, 1'b0);
        step(); stop = 1'b0;
        step();

        // Cycle counter saturation
        t = 8'd40; start = 1'b1; step(); start = 1'b0;
        step(79);
        stop = 1'b1;
        expect_result(8'd0, 6'd63, 1'b0);
        step(); stop = 1'b0;
        step();

        // Reset mid-RUN discards everything
        t = 8'd50; start = 1'b1; step(); step(); start = 1'b0;
        check("rst_pre_err", 32'(err), 1);
        rstn = 1'b0; step(3); rstn = 1'b1;
        check("rst2_valid", 32'(res_valid), 0);
        check("rst2_busy", 32'(busy), 0);
        check("rst2_err", 32'(err), 0);
        check("rst2_tout", 32'(timed_out), 0);
        check("rst2_ticks", 32'(elapsed_ticks), 0);
        check("rst2_cycles", 32'(elapsed_cycles), 0);
        check("rst2_state", 32'(dbg_state), 0);
        t = 8'd60; stop = 1'b1; step(); stop = 1'b0;
        step(5);
        check("rst2_no_result", 32'(res_valid), 0);

        // Final report
        check("queue_drained", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
